// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between requester FIFOs, the UART transmitter and uart_tx_arbiter.
// master: arbiter side; slave: requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DBITS = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DBITS-1:0]   req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ-1:0]         req_ready;
  logic                    tx_start;
  logic [DBITS-1:0]        tx_data;
  logic                    tx_done;
  logic [$clog2(NREQ)-1:0] grant_idx;
  logic                    busy;
  logic                    timeout_err;
  logic                    err_clr;

  modport master (
    input  req_valid, req_data, req_last, tx_done, err_clr,
    output req_ready, tx_start, tx_data, grant_idx, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_done, err_clr,
    input  req_ready, tx_start, tx_data, grant_idx, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NREQ byte producers, one byte per grant.
// Define UART_ARB_LOCK_EN to hold the grant on one requester until it sends a req_last byte.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DBITS       = 8,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input logic               clk_100MHz,
  input logic               reset_n,
  uart_tx_arbiter_if.master bus
);

  localparam int              IW        = $clog2(NREQ);
  localparam int              WW        = $clog2(TIMEOUT_CYC);
  localparam logic [WW-1:0]   WDOG_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

`ifdef UART_ARB_LOCK_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_LOCKED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_t;
`endif

  state_t           state_q;
  logic [NREQ-1:0]  req_ready_q;
  logic             tx_start_q;
  logic [DBITS-1:0] tx_data_q;
  logic [IW-1:0]    grant_idx_q;
  logic [IW-1:0]    ptr_q;
  logic             busy_q;
  logic             timeout_err_q;
  logic [WW-1:0]    wdog_q;

  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand_idx;
  logic [IW-1:0]    sel_idx;
  logic             win_vld;
  logic             wdog_end;
  logic [DBITS-1:0] sel_data;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_vld && bus.req_valid[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    sel_idx = win_idx;
`ifdef UART_ARB_LOCK_EN
    if (state_q == S_LOCKED) sel_idx = grant_idx_q;
`endif
  end

  assign sel_data = bus.req_data[int'(sel_idx)*DBITS +: DBITS];
  assign wdog_end = (wdog_q == WDOG_LAST);

`ifdef UART_ARB_LOCK_EN
  logic last_q;
  logic sel_last;
  assign sel_last = bus.req_last[sel_idx];
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
`endif

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_idx_q   <= '0;
      ptr_q         <= IW'(NREQ - 1);
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
`ifdef UART_ARB_LOCK_EN
      last_q        <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      if (bus.err_clr) timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q     <= S_GRANT;
            busy_q      <= 1'b1;
            ptr_q       <= win_idx;
            grant_idx_q <= win_idx;
            tx_data_q   <= sel_data;
            req_ready_q <= ONE_HOT0 << win_idx;
            tx_start_q  <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            last_q      <= sel_last;
`endif
          end
        end
        S_GRANT: begin
          state_q <= S_WAIT;
          wdog_q  <= '0;
        end
        S_WAIT: begin
          // tx_done has priority over a watchdog expiring in the same cycle.
          if (bus.tx_done) begin
`ifdef UART_ARB_LOCK_EN
            if (!last_q) begin
              state_q <= S_LOCKED;
              wdog_q  <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`endif
          end else if (wdog_end) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
`ifdef UART_ARB_LOCK_EN
        S_LOCKED: begin
          // Mid-message: only the owner may continue; pointer stays put.
          if (bus.req_valid[grant_idx_q]) begin
            state_q     <= S_GRANT;
            tx_data_q   <= sel_data;
            req_ready_q <= ONE_HOT0 << grant_idx_q;
            tx_start_q  <= 1'b1;
            last_q      <= sel_last;
          end else if (wdog_end) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
